// File: rtl/slow_clock_period_meter.sv
// Measures the half-period of a slow asynchronous square wave in basys_clock cycles and
// reports it in the divider's terminal-count convention (toggle every N cycles -> N-1).
module slow_clock_period_meter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 100000000,
    parameter int unsigned TOL         = 1
) (
    input  logic        basys_clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        sig_in,
    output logic [31:0] m_est,
    output logic        valid,
    output logic        locked,
    output logic        timeout
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;

    localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT);
    localparam logic [32:0] TOL_C     = 33'(TOL);

    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   sync_level;
    logic                   sig_edge;

    logic [1:0]  state_q, state_d;
    logic [31:0] count_q, count_d;
    logic [31:0] m_est_q, m_est_d;
    logic        valid_q, valid_d;
    logic        locked_q, locked_d;
    logic        timeout_q, timeout_d;
    // Set once a sample exists to compare against since the last ACQUIRE.
    logic        have_prev_q, have_prev_d;

    logic [32:0] cur_w;
    logic [32:0] prev_w;
    logic [32:0] diff;
    logic        within_tol;
    logic        at_timeout;

    // Synchronizer chain plus one flop of history for edge detection.
    always_ff @(posedge basys_clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            prev_q <= sync_level;
        end
    end

    assign sync_level = sync_q[SYNC_STAGES-1];
    assign sig_edge   = sync_level ^ prev_q;

    // Widened to 33 bits so the absolute difference never wraps.
    always_comb begin
        cur_w  = {1'b0, count_q};
        prev_w = {1'b0, m_est_q};
        if (cur_w >= prev_w) begin
            diff = cur_w - prev_w;
        end else begin
            diff = prev_w - cur_w;
        end
        within_tol = (diff <= TOL_C);
    end

    assign at_timeout = (count_q >= TIMEOUT_C);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        m_est_d     = m_est_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        timeout_d   = timeout_q;
        have_prev_d = have_prev_q;

        if (!enable) begin
            state_d  = ST_IDLE;
            count_d  = '0;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    count_d     = '0;
                    have_prev_d = 1'b0;
                    state_d     = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (sig_edge) begin
                        count_d = '0;
                        state_d = ST_MEASURE;
                    end else if (at_timeout) begin
                        count_d   = '0;
                        timeout_d = 1'b1;
                        locked_d  = 1'b0;
                    end else begin
                        count_d = count_q + 32'd1;
                    end
                end
                ST_MEASURE: begin
                    // An edge landing on the timeout cycle still counts as a sample.
                    if (sig_edge) begin
                        count_d     = '0;
                        m_est_d     = count_q;
                        valid_d     = 1'b1;
                        timeout_d   = 1'b0;
                        locked_d    = have_prev_q && within_tol;
                        have_prev_d = 1'b1;
                    end else if (at_timeout) begin
                        count_d     = '0;
                        timeout_d   = 1'b1;
                        locked_d    = 1'b0;
                        have_prev_d = 1'b0;
                        state_d     = ST_ACQUIRE;
                    end else begin
                        count_d = count_q + 32'd1;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    count_d  = '0;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge basys_clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            m_est_q     <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
            have_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            m_est_q     <= m_est_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            timeout_q   <= timeout_d;
            have_prev_q <= have_prev_d;
        end
    end

    assign m_est   = m_est_q;
    assign valid   = valid_q;
    assign locked  = locked_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_slow_clock_period_meter.sv
// Directed bench for slow_clock_period_meter: steady periods, lock tracking, timeout,
// edge-at-timeout, back-to-back edges, asynchronous reset and enable drop.
module tb_slow_clock_period_meter;

    logic        basys_clock;
    logic        reset;
    logic        enable;
    logic        sig_in;
    logic [31:0] m_est;
    logic        valid;
    logic        locked;
    logic        timeout;

    int n_cmp = 0;
    int n_err = 0;

    slow_clock_period_meter #(
        .SYNC_STAGES(2),
        .TIMEOUT    (50),
        .TOL        (1)
    ) dut (
        .basys_clock(basys_clock),
        .reset      (reset),
        .enable     (enable),
        .sig_in     (sig_in),
        .m_est      (m_est),
        .valid      (valid),
        .locked     (locked),
        .timeout    (timeout)
    );

    initial basys_clock = 1'b0;
    always #5 basys_clock = ~basys_clock;

    task automatic tick();
        @(posedge basys_clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic v, input logic [31:0] m,
                             input logic l, input logic t);
        check({tag, ".valid"}, {31'd0, valid}, {31'd0, v});
        check({tag, ".m_est"}, m_est, m);
        check({tag, ".locked"}, {31'd0, locked}, {31'd0, l});
        check({tag, ".timeout"}, {31'd0, timeout}, {31'd0, t});
    endtask

    // Toggle sig_in, check the outputs when a resulting valid is due (3 cycles later),
    // check the pulse is gone one cycle after, then hold the level for n cycles in total.
    task automatic half(input int n, input logic v, input logic [31:0] m, input logic l,
                        input logic t, input string tag);
        sig_in = ~sig_in;
        repeat (3) tick();
        check_all(tag, v, m, l, t);
        tick();
        check({tag, ".pulse_end"}, {31'd0, valid}, 32'd0);
        repeat (n - 4) tick();
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        sig_in = 1'b0;
        repeat (2) tick();
        check_all("reset", 1'b0, 32'd0, 1'b0, 1'b0);

        reset  = 1'b0;
        enable = 1'b1;
        repeat (2) tick();

        // Steady 5-cycle half-period, then 6 and 9.
        half(5, 1'b0, 32'd0, 1'b0, 1'b0, "acq0");
        half(5, 1'b1, 32'd4, 1'b0, 1'b0, "s1");
        half(5, 1'b1, 32'd4, 1'b1, 1'b0, "s2");
        half(6, 1'b1, 32'd4, 1'b1, 1'b0, "s3");
        half(9, 1'b1, 32'd5, 1'b1, 1'b0, "p6");
        half(7, 1'b1, 32'd8, 1'b0, 1'b0, "p9");
        half(7, 1'b1, 32'd6, 1'b0, 1'b0, "p7a");

        // Freeze the input after lock: counter reaches 50 and timeout fires.
        half(53, 1'b1, 32'd6, 1'b1, 1'b0, "p7b");
        check_all("to_pre", 1'b0, 32'd6, 1'b1, 1'b0);
        tick();
        check_all("to_set", 1'b0, 32'd6, 1'b0, 1'b1);
        half(7, 1'b0, 32'd6, 1'b0, 1'b1, "to_acq");
        half(51, 1'b1, 32'd6, 1'b0, 1'b0, "to_rec");

        // Previous edge arrived exactly when counter == TIMEOUT.
        half(5, 1'b1, 32'd50, 1'b0, 1'b0, "edge_at_to");
        half(5, 1'b1, 32'd4, 1'b0, 1'b0, "r1");
        half(5, 1'b1, 32'd4, 1'b1, 1'b0, "r2");

        // Two edges one cycle apart.
        sig_in = ~sig_in;
        tick();
        sig_in = ~sig_in;
        repeat (2) tick();
        check_all("b2b_a", 1'b1, 32'd4, 1'b1, 1'b0);
        tick();
        check_all("b2b_b", 1'b1, 32'd0, 1'b0, 1'b0);
        tick();
        check("b2b.pulse_end", {31'd0, valid}, 32'd0);
        tick();
        half(5, 1'b1, 32'd4, 1'b0, 1'b0, "b2b_c");
        half(5, 1'b1, 32'd4, 1'b1, 1'b0, "b2b_d");

        // Asynchronous reset mid-period while locked.
        repeat (2) tick();
        reset  = 1'b1;
        sig_in = 1'b0;
        #1;
        check_all("rst_async", 1'b0, 32'd0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        repeat (2) tick();
        half(5, 1'b0, 32'd0, 1'b0, 1'b0, "post_rst_acq");
        half(5, 1'b1, 32'd4, 1'b0, 1'b0, "post_rst_s1");
        half(5, 1'b1, 32'd4, 1'b1, 1'b0, "post_rst_s2");

        // Enable dropped while locked.
        enable = 1'b0;
        tick();
        check_all("en_off", 1'b0, 32'd4, 1'b0, 1'b0);
        sig_in = ~sig_in;
        repeat (4) tick();
        check_all("en_off_edge1", 1'b0, 32'd4, 1'b0, 1'b0);
        sig_in = ~sig_in;
        repeat (4) tick();
        check_all("en_off_edge2", 1'b0, 32'd4, 1'b0, 1'b0);
        enable = 1'b1;
        repeat (2) tick();
        half(5, 1'b0, 32'd4, 1'b0, 1'b0, "en_acq");
        half(5, 1'b1, 32'd4, 1'b0, 1'b0, "en_s1");
        half(5, 1'b1, 32'd4, 1'b1, 1'b0, "en_s2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
